mac_result_capture: RTL and testbench
=====================================

MAC_RESULT_CAPTURE -- requirements
Module: mac_result_capture

Interface
REQ-001 Parameter ACC_W, default 32: width of the accumulator value and of the captured data.
REQ-002 Parameter DEPTH, default 4: result FIFO depth in entries; DEPTH SHALL be a power of 2 and at least 2.
REQ-003 Port clk, input, 1: sole clock; all state SHALL change on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port AccumReset, input, 1: window marker, driven by the same source that clears the multiply-accumulate unit.
REQ-006 Port LocalReg, input, ACC_W: running accumulator value from the multiply-accumulate unit.
REQ-007 Port out_ready, input, 1: downstream accepts the head entry.
REQ-008 Port clr_ovf, input, 1: clears the sticky overflow flag.
REQ-009 Port out_valid, output, 1: FIFO is not empty.
REQ-010 Port out_data, output, ACC_W: captured accumulation of the head entry.
REQ-011 Port out_len, output, 8: window length of the head entry, in cycles.
REQ-012 Port fifo_level, output, log2(DEPTH)+1: number of occupied entries.
REQ-013 Port overflow, output, 1: sticky flag; set when a result is dropped.

Function
REQ-014 All sampling SHALL occur on the rising edge of clk.
REQ-015 The block SHALL implement a state machine with three states: SYNC, HOLD and ACCUM.
REQ-016 SYNC is the state after reset; it SHALL ignore LocalReg and move to HOLD on the first edge where AccumReset=1.
REQ-017 In HOLD, AccumReset=1 SHALL keep the state in HOLD and produce no capture.
REQ-018 In HOLD, AccumReset=0 SHALL move the state to ACCUM and load the length counter with 1.
REQ-019 In ACCUM, AccumReset=0 SHALL increment the length counter, saturating at 255.
REQ-020 In ACCUM, AccumReset=1 SHALL push {length counter, LocalReg sampled on that same edge} into the FIFO and move to HOLD.
REQ-021 Capture latency: the pushed entry SHALL be visible on out_valid, out_data and out_len in the cycle after the closing edge.
REQ-022 The FIFO SHALL be first-word-fall-through: out_data and out_len always present the head entry, and out_valid = (fifo_level != 0).
REQ-023 A pop SHALL occur on any edge where out_valid=1 and out_ready=1.
REQ-024 out_data and out_len SHALL be held stable while out_valid=1 and out_ready=0.
REQ-025 A push while the FIFO is full and no pop occurs SHALL be dropped, set overflow, and leave the contents unchanged.
REQ-026 A simultaneous push and pop while full SHALL accept both; the level stays at DEPTH and overflow is not set.
REQ-027 A simultaneous push and pop while empty SHALL not occur, because out_valid=0 when empty; the push SHALL complete normally.
REQ-028 The read and write pointers SHALL wrap modulo DEPTH.
REQ-029 fifo_level SHALL be updated in the same edge as the push or pop that changes it.
REQ-030 clr_ovf=1 SHALL clear overflow on that edge.
REQ-031 If clr_ovf=1 and a drop occur on the same edge, the set SHALL win and overflow becomes 1.
REQ-032 LocalReg SHALL be captured unmodified at full ACC_W width, with no sign or width conversion.

Reset
REQ-033 rst=1 SHALL immediately force the state to SYNC, the length counter to 0, both pointers to 0, fifo_level=0, out_valid=0 and overflow=0.
REQ-034 While rst=1, out_data and out_len SHALL read 0.
REQ-035 Reset asserted mid-window or with a non-empty FIFO SHALL discard the partial window and all buffered entries.
REQ-036 After rst deasserts, the first window boundary SHALL only arm the block (SYNC to HOLD) and SHALL NOT produce a capture.

Verification
REQ-037 Pulse AccumReset for 1 cycle every 11 cycles; LocalReg ramps 0x3F01, then 0x5B73, then +0x10 per cycle -> each entry has out_len=10 and out_data equal to LocalReg at the closing edge.
REQ-038 Hold AccumReset=1 for 3 consecutive cycles, then AccumReset=0 for 4 cycles, then AccumReset=1 -> exactly one entry with out_len=4.
REQ-039 Hold out_ready=0 and close 5 windows with DEPTH=4 -> fifo_level=4, overflow=1, and the entries read back are windows 1-4 in order; then pulse clr_ovf -> overflow=0.
REQ-040 FIFO full, out_ready=1 on the edge a window closes -> level stays 4, overflow stays 0, and the new entry appears last.
REQ-041 Hold AccumReset=0 for 300 cycles after arming -> out_len=255 and out_data=LocalReg at the closing edge (e.g. 0xFFFFFFFF).
REQ-042 Assert rst asynchronously with 2 entries buffered and a window open -> out_valid=0 at once; the next boundary after release produces no entry.

Source files
------------

// File: rtl/mac_result_capture.sv
// mac_result_capture
//   Watches the window marker that clears a multiply-accumulate unit and, at
//   the end of every complete window, captures the accumulator value together
//   with the window length (in cycles) into a small first-word-fall-through
//   result FIFO.
//
// Ports
//   clk         : sole clock, rising edge
//   rst         : asynchronous active-high reset
//   AccumReset  : window marker (same source that clears the MAC)
//   LocalReg    : running accumulator value, ACC_W bits
//   out_ready   : downstream accepts the head entry
//   clr_ovf     : clears the sticky overflow flag
//   out_valid   : FIFO not empty
//   out_data    : accumulation of the head entry (0 when empty)
//   out_len     : window length of the head entry (0 when empty)
//   fifo_level  : number of occupied entries
//   overflow    : sticky, set when a result had to be dropped
module mac_result_capture #(
    parameter int ACC_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   AccumReset,
    input  logic [ACC_W-1:0]       LocalReg,
    input  logic                   out_ready,
    input  logic                   clr_ovf,
    output logic                   out_valid,
    output logic [ACC_W-1:0]       out_data,
    output logic [7:0]             out_len,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = ACC_W + 8;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        HOLD  = 2'd1,
        ACCUM = 2'd2
    } state_t;

    state_t          state_q;
    logic [7:0]      len_q;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            ovf_q, ovf_d;
    logic [EW-1:0]   mem_q [DEPTH];

    logic            push, pop, full, do_write, drop;
    logic [EW-1:0]   head;

    // Window FSM: SYNC waits for the first marker so a window that was
    // already running when reset released is never reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SYNC;
            len_q   <= 8'd0;
        end else begin
            case (state_q)
                SYNC: begin
                    if (AccumReset) state_q <= HOLD;
                end
                HOLD: begin
                    if (!AccumReset) begin
                        state_q <= ACCUM;
                        len_q   <= 8'd1;
                    end
                end
                ACCUM: begin
                    if (AccumReset) begin
                        state_q <= HOLD;
                    end else if (len_q != 8'hFF) begin
                        len_q <= len_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= SYNC;
                    len_q   <= 8'd0;
                end
            endcase
        end
    end

    // The closing edge of a window is the push edge; LocalReg on that edge
    // is the final accumulation.
    assign push     = (state_q == ACCUM) && AccumReset;
    assign pop      = (level_q != '0) && out_ready;
    assign full     = (level_q == LW'(DEPTH));
    // When full, a push only fits if the head leaves on the same edge.
    assign do_write = push && (!full || pop);
    assign drop     = push && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        // Power-of-two depth: pointer increment wraps naturally.
        if (do_write) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_write && !pop)      level_d = level_q + LW'(1);
        else if (!do_write && pop) level_d = level_q - LW'(1);
        // A drop on the same edge as a clear leaves the flag set.
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: contents are only visible through level_q.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_write && (wr_ptr_q == PW'(gi))) begin
                    mem_q[gi] <= {len_q, LocalReg};
                end
            end
        end
    endgenerate

    assign head       = mem_q[rd_ptr_q];
    assign out_valid  = (level_q != '0);
    // Masked so that an empty (or resetting) FIFO presents zeros.
    assign out_data   = out_valid ? head[ACC_W-1:0] : '0;
    assign out_len    = out_valid ? head[EW-1:ACC_W] : 8'd0;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_mac_result_capture.sv
module tb_mac_result_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        AccumReset = 1'b0;
    logic [31:0] LocalReg = 32'h0;
    logic        out_ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_len;
    logic [2:0]  fifo_level;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    mac_result_capture #(.ACC_W(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .AccumReset(AccumReset), .LocalReg(LocalReg),
        .out_ready(out_ready), .clr_ovf(clr_ovf), .out_valid(out_valid),
        .out_data(out_data), .out_len(out_len), .fifo_level(fifo_level),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic cycle(input logic ar, input logic [31:0] lr);
        AccumReset = ar;
        LocalReg   = lr;
        @(posedge clk);
        #1;
    endtask

    // len marker-low cycles, then the closing edge carrying d.
    task automatic window(input int len, input logic [31:0] d, input logic rdy_open,
                          input logic rdy_close, input logic clr_close);
        out_ready = rdy_open;
        for (int i = 0; i < len; i++) cycle(1'b0, 32'h0000_0100 + i);
        out_ready = rdy_close;
        clr_ovf   = clr_close;
        cycle(1'b1, d);
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", overflow); end
        n_checks++; if (out_data !== 32'h0 || out_len !== 8'd0) begin n_fail++; $display("FAIL reset_data got %h/%0d want 0/0", out_data, out_len); end
        rst = 1'b0;
    endtask

    task automatic test_first_boundary;
        cycle(1'b0, 32'h1111);
        cycle(1'b0, 32'h2222);
        cycle(1'b1, 32'h3333);
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL arm_no_capture got level %0d want 0", fifo_level); end
        $display("arm: level=%0d", fifo_level);
    endtask

    task automatic test_periodic;
        logic [31:0] lr;
        int c;
        c = 0;
        lr = 32'h0;
        out_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 11; k++) begin
                if (c == 0) lr = 32'h3F01;
                else if (c == 1) lr = 32'h5B73;
                else lr = lr + 32'h10;
                cycle(k == 10, lr);
                c++;
            end
            $display("periodic: window %0d len=%0d data=%h", w, out_len, out_data);
            n_checks++; if (out_len !== 8'd10) begin n_fail++; $display("FAIL periodic_len got %0d want 10", out_len); end
            n_checks++; if (out_data !== lr) begin n_fail++; $display("FAIL periodic_data got %h want %h", out_data, lr); end
            n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL periodic_level got %0d want 1", fifo_level); end
        end
    endtask

    task automatic test_long_hold;
        out_ready = 1'b1;
        repeat (3) cycle(1'b1, 32'hDEAD);
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL hold_no_capture got level %0d want 0", fifo_level); end
        repeat (4) cycle(1'b0, 32'h77);
        cycle(1'b1, 32'hABCD_1234);
        $display("hold: len=%0d data=%h level=%0d", out_len, out_data, fifo_level);
        n_checks++; if (out_len !== 8'd4) begin n_fail++; $display("FAIL hold_len got %0d want 4", out_len); end
        n_checks++; if (out_data !== 32'hABCD_1234) begin n_fail++; $display("FAIL hold_data got %h want abcd1234", out_data); end
        n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL hold_level got %0d want 1", fifo_level); end
        cycle(1'b1, 32'h0);
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL hold_pop got level %0d want 0", fifo_level); end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow;
        logic [31:0] exp_d [4];
        logic [7:0]  exp_l [4];
        exp_d = '{32'h1002, 32'h1003, 32'h1004, 32'h2006};
        exp_l = '{8'd2, 8'd3, 8'd4, 8'd2};
        for (int i = 1; i <= 5; i++) begin
            window(i, 32'h1000 + i, 1'b0, 1'b0, 1'b0);
            $display("fill: window %0d level=%0d ovf=%0b", i, fifo_level, overflow);
            if (i == 4) begin
                n_checks++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin n_fail++; $display("FAIL fill4 got level %0d ovf %0b want 4/0", fifo_level, overflow); end
            end
        end
        n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level got %0d want 4", fifo_level); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %0b want 1", overflow); end
        cycle(1'b1, 32'h0);
        n_checks++; if (out_data !== 32'h1001 || out_len !== 8'd1) begin n_fail++; $display("FAIL ovf_head_stable got %h/%0d want 1001/1", out_data, out_len); end
        clr_ovf = 1'b1;
        cycle(1'b1, 32'h0);
        clr_ovf = 1'b0;
        n_checks++; if (overflow !== 1'b0 || fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_clear got ovf %0b level %0d want 0/4", overflow, fifo_level); end
        // Drop and clear on the same edge: set must win.
        window(3, 32'h3333, 1'b0, 1'b0, 1'b1);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %0b want 1", overflow); end
        clr_ovf = 1'b1;
        cycle(1'b1, 32'h0);
        clr_ovf = 1'b0;
        // Full FIFO, pop on the closing edge: both accepted.
        window(2, 32'h2006, 1'b0, 1'b1, 1'b0);
        n_checks++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin n_fail++; $display("FAIL full_pushpop got level %0d ovf %0b want 4/0", fifo_level, overflow); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            $display("readback: entry %0d len=%0d data=%h", k, out_len, out_data);
            n_checks++; if (out_data !== exp_d[k] || out_len !== exp_l[k]) begin n_fail++; $display("FAIL readback_%0d got %h/%0d want %h/%0d", k, out_data, out_len, exp_d[k], exp_l[k]); end
            cycle(1'b1, 32'h0);
        end
        n_checks++; if (fifo_level !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL drained got level %0d valid %0b want 0/0", fifo_level, out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_saturate;
        window(300, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        $display("saturate: len=%0d data=%h", out_len, out_data);
        n_checks++; if (out_len !== 8'd255) begin n_fail++; $display("FAIL sat_len got %0d want 255", out_len); end
        n_checks++; if (out_data !== 32'hFFFF_FFFF || out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_data got %h valid %0b want ffffffff/1", out_data, out_valid); end
        out_ready = 1'b1;
        cycle(1'b1, 32'h0);
        out_ready = 1'b0;
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL sat_pop got level %0d want 0", fifo_level); end
    endtask

    task automatic test_async_reset;
        window(1, 32'hA1, 1'b0, 1'b0, 1'b0);
        window(2, 32'hA2, 1'b0, 1'b0, 1'b0);
        n_checks++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL ar_prefill got level %0d want 2", fifo_level); end
        repeat (3) cycle(1'b0, 32'h55);
        #3 rst = 1'b1;
        #1;
        $display("async reset: valid=%0b level=%0d", out_valid, fifo_level);
        n_checks++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin n_fail++; $display("FAIL ar_immediate got valid %0b level %0d want 0/0", out_valid, fifo_level); end
        n_checks++; if (out_data !== 32'h0 || out_len !== 8'd0) begin n_fail++; $display("FAIL ar_data got %h/%0d want 0/0", out_data, out_len); end
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(1'b1, 32'h66);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_first_boundary got valid %0b want 0", out_valid); end
        window(2, 32'hB2, 1'b0, 1'b0, 1'b0);
        $display("after reset: len=%0d data=%h level=%0d", out_len, out_data, fifo_level);
        n_checks++; if (out_len !== 8'd2 || out_data !== 32'hB2 || fifo_level !== 3'd1) begin n_fail++; $display("FAIL ar_recover got %0d/%h/%0d want 2/b2/1", out_len, out_data, fifo_level); end
    endtask

    initial begin
        test_reset;
        test_first_boundary;
        test_periodic;
        test_long_hold;
        test_overflow;
        test_saturate;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
